// File: rtl/key_debounce_scan.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_scan
// Description : Synchronises and debounces active-low push buttons into a clean
//               key bus and emits one-shot encoded press events (valid/ready).
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_scan #(
    parameter int NKEYS           = 6,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CODE_W          = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NKEYS:1]    key_raw,
    output logic [NKEYS:1]    key_clean,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_ovf
);

    localparam int                 c_cnt_w    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [NKEYS:1]     c_all_ones = '1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    logic [1:0]         r_rst_sync;
    logic               w_rst_n;
    logic [NKEYS:1]     r_sync1;
    logic [NKEYS:1]     r_sync2;
    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [NKEYS:1]     r_cand;
    int                 w_zero_cnt;
    logic [CODE_W-1:0]  w_press_idx;
    logic               w_fire;
    logic               w_event;

    // Reset asserts asynchronously but releases in step with clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sync1 <= c_all_ones;
            r_sync2 <= c_all_ones;
        end else begin
            r_sync1 <= key_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_zero_cnt  = 0;
        w_press_idx = '0;
        for (int i = 1; i <= NKEYS; i++) begin
            if (!r_cand[i]) begin
                w_zero_cnt  = w_zero_cnt + 1;
                w_press_idx = CODE_W'(i);
            end
        end
    end

    assign w_fire  = (r_state == ST_DEBOUNCE) && (r_sync2 == r_cand) && (r_cnt == c_cnt_max);
    assign w_event = w_fire && (w_zero_cnt == 1);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_cand    <= c_all_ones;
            key_clean <= c_all_ones;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_sync2 != c_all_ones) begin
                        r_cand  <= r_sync2;
                        r_cnt   <= '0;
                        r_state <= ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (r_sync2 != r_cand) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == c_cnt_max) begin
                        key_clean <= r_cand;
                        r_cnt     <= '0;
                        r_state   <= ST_HELD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    // Pattern changes while held are ignored; only a full release counts.
                    if (r_sync2 != c_all_ones) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_cnt_max) begin
                        key_clean <= c_all_ones;
                        r_cnt     <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase

            if (w_event) begin
                if (!key_valid || key_ready) begin
                    key_code  <= w_press_idx;
                    key_valid <= 1'b1;
                end else begin
                    key_ovf <= 1'b1;
                end
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_debounce_scan
// Description : Scoreboard bench for key_debounce_scan (NKEYS=6, DEBOUNCE_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debounce_scan;

    localparam int NKEYS  = 6;
    localparam int DEB    = 4;
    localparam int CODE_W = 3;

    logic              clk;
    logic              rst_n;
    logic [NKEYS:1]    key_raw;
    logic [NKEYS:1]    key_clean;
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_ready;
    logic              key_ovf;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    key_debounce_scan #(
        .NKEYS           (NKEYS),
        .DEBOUNCE_CYCLES (DEB),
        .CODE_W          (CODE_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_raw   (key_raw),
        .key_clean (key_clean),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_ovf   (key_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_clean"}, int'(key_clean), 'h3F);
        check({name, "_code"},  int'(key_code),  0);
        check({name, "_valid"}, int'(key_valid), 0);
        check({name, "_ovf"},   int'(key_ovf),   0);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!key_valid && n < budget) begin
            wait_cyc(1);
            n++;
        end
        check({name, "_valid_timeout"}, int'(key_valid), 1);
    endtask

    // Monitor: an accept happens on the next edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n && key_valid && key_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got code %0d expected none", key_code);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(key_code) != e) begin
                    errors++;
                    $display("FAIL event_code: got %0d expected %0d", key_code, e);
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        key_raw   = 6'b111111;
        key_ready = 1'b0;
        wait_cyc(3);
        check_reset_vals("reset");
        rst_n = 1'b1;
        wait_cyc(5);

        // Clean press of key 3, ready high
        key_ready = 1'b1;
        key_raw   = 6'b111011;
        exp_q.push_back(3);
        wait_cyc(6);
        check("t1_clean_early", int'(key_clean), 'h3F);
        wait_cyc(1);
        check("t1_clean", int'(key_clean), 'h3B);
        check("t1_valid", int'(key_valid), 1);
        check("t1_code",  int'(key_code),  3);
        wait_cyc(1);
        check("t1_valid_fall", int'(key_valid), 0);
        key_raw = 6'b111111;
        wait_cyc(5);
        check("t1_rel_early", int'(key_clean), 'h3B);
        wait_cyc(1);
        check("t1_rel", int'(key_clean), 'h3F);

        // Bounce on key 1, then stable
        for (int i = 0; i < 10; i++) begin
            key_raw = 6'b111110;
            wait_cyc(2);
            key_raw = 6'b111111;
            wait_cyc(2);
        end
        check("t2_clean_bounce", int'(key_clean), 'h3F);
        check("t2_valid_bounce", int'(key_valid), 0);
        key_raw = 6'b111110;
        exp_q.push_back(1);
        wait_cyc(7);
        check("t2_clean", int'(key_clean), 'h3E);
        check("t2_valid", int'(key_valid), 1);
        check("t2_code",  int'(key_code),  1);
        key_raw = 6'b111111;
        wait_cyc(8);
        check("t2_rel", int'(key_clean), 'h3F);

        // Combo: no event expected
        key_raw = 6'b011110;
        wait_cyc(7);
        check("t3_clean", int'(key_clean), 'h1E);
        check("t3_valid", int'(key_valid), 0);
        key_raw = 6'b111111;
        wait_cyc(8);
        check("t3_rel", int'(key_clean), 'h3F);

        // Backpressure: key 2 then key 5 with ready low
        key_ready = 1'b0;
        key_raw   = 6'b111101;
        exp_q.push_back(2);
        wait_cyc(7);
        check("t4_valid", int'(key_valid), 1);
        check("t4_code",  int'(key_code),  2);
        check("t4_ovf0",  int'(key_ovf),   0);
        key_raw = 6'b111111;
        wait_cyc(8);
        key_raw = 6'b101111;
        wait_cyc(7);
        check("t4_clean5", int'(key_clean), 'h2F);
        check("t4_code_kept", int'(key_code), 2);
        check("t4_ovf", int'(key_ovf), 1);
        key_raw = 6'b111111;
        wait_cyc(8);
        check("t4_ignored_ready", int'(key_valid), 1);
        key_ready = 1'b1;
        wait_cyc(1);
        check("t4_valid_after_accept", int'(key_valid), 0);
        check("t4_ovf_sticky", int'(key_ovf), 1);
        key_ready = 1'b0;

        rst_n = 1'b0;
        wait_cyc(2);
        check_reset_vals("rst2");
        rst_n = 1'b1;
        wait_cyc(4);

        // Accept and new event on the same edge
        key_raw = 6'b110111;
        exp_q.push_back(4);
        wait_cyc(7);
        check("t5_code4", int'(key_code), 4);
        key_raw = 6'b111111;
        wait_cyc(8);
        key_raw = 6'b011111;
        exp_q.push_back(6);
        wait_cyc(6);
        key_ready = 1'b1;
        wait_cyc(1);
        key_ready = 1'b0;
        check("t5_code6", int'(key_code),  6);
        check("t5_valid", int'(key_valid), 1);
        check("t5_ovf",   int'(key_ovf),   0);
        key_raw = 6'b111111;
        wait_cyc(8);
        key_ready = 1'b1;
        wait_cyc(1);
        check("t5_drain", int'(key_valid), 0);
        key_ready = 1'b0;

        // Reset mid-debounce, then while an event is pending
        key_raw = 6'b111110;
        wait_cyc(4);
        rst_n = 1'b0;
        #1;
        check_reset_vals("t6_mid_deb");
        wait_cyc(2);
        rst_n = 1'b1;
        wait_valid("t6_redeb", 30);
        check("t6_code",  int'(key_code),  1);
        check("t6_clean", int'(key_clean), 'h3E);
        rst_n = 1'b0;
        #1;
        check_reset_vals("t6_mid_valid");
        wait_cyc(2);
        rst_n = 1'b1;
        exp_q.push_back(1);
        wait_valid("t6_redeb2", 30);
        key_ready = 1'b1;
        wait_cyc(1);
        check("t6_drain", int'(key_valid), 0);
        key_ready = 1'b0;
        key_raw   = 6'b111111;
        wait_cyc(8);
        check("t6_rel", int'(key_clean), 'h3F);

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
